prbs_qam_mapper: RTL

PRBS_QAM_MAPPER -- requirements
Module: prbs_qam_mapper

---
 rtl/mod_pkg.sv | 40 ++++
 rtl/prbs_stepper.sv | 34 +++
 rtl/prbs_qam_mapper.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared mode encodings, Gray level table and default PRBS taps
package mod_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'b00,
    MODE_QPSK  = 2'b01,
    MODE_QAM16 = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    LVL_NEG_FULL,
    LVL_NEG_THIRD,
    LVL_POS_THIRD,
    LVL_POS_FULL
  } level_e;

  // x^7 + x^6 + 1
  localparam logic [6:0] DEFAULT_TAPS = 7'b1100000;

  function automatic logic [2:0] bits_per_symbol(input mode_e m);
    case (m)
      MODE_BPSK:  return 3'd1;
      MODE_QPSK:  return 3'd2;
      MODE_QAM16: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  // pair = {first bit in PRBS order, second bit}
  function automatic level_e gray_level(input logic [1:0] pair);
    case (pair)
      2'b00:   return LVL_NEG_FULL;
      2'b01:   return LVL_NEG_THIRD;
      2'b11:   return LVL_POS_THIRD;
      default: return LVL_POS_FULL;
    endcase
  endfunction

endpackage

// File: rtl/prbs_stepper.sv
// rtl/prbs_stepper.sv - combinational 1/2/4-step Fibonacci LFSR advance
// o_bits[n] is the n-th PRBS bit emitted; bits beyond i_nsteps are don't-care.
module prbs_stepper
  import mod_pkg::*;
#(
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
  input  logic [LFSR_W-1:0] i_state,
  input  logic [2:0]        i_nsteps,
  output logic [LFSR_W-1:0] o_next,
  output logic [3:0]        o_bits
);

  logic [LFSR_W-1:0] w_st [0:4];

  assign w_st[0] = i_state;

  for (genvar g = 0; g < 4; g++) begin : g_step
    assign o_bits[g]  = w_st[g][LFSR_W-1];
    assign w_st[g+1]  = {w_st[g][LFSR_W-2:0], ^(w_st[g] & TAPS)};
  end

  always_comb begin
    o_next = i_state;
    case (i_nsteps)
      3'd1:    o_next = w_st[1];
      3'd2:    o_next = w_st[2];
      3'd4:    o_next = w_st[4];
      default: o_next = i_state;
    endcase
  end

endmodule

// File: rtl/prbs_qam_mapper.sv
// rtl/prbs_qam_mapper.sv - PRBS source mapped to BPSK/QPSK/16-QAM I/Q symbols
// Single-entry output register with valid/ready handshake and optional framing.
module prbs_qam_mapper
  import mod_pkg::*;
#(
  parameter int                LFSR_W = 7,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter int                OUT_W  = 8,
  parameter int                AMP    = 96
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LFSR_W-1:0]       lfsr_seed,
  input  logic                    lfsr_load,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [15:0]             frame_len,
  output logic signed [OUT_W-1:0] I_out,
  output logic signed [OUT_W-1:0] Q_out,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic                    last_out
);

  localparam logic signed [OUT_W-1:0] P_FULL  = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0] N_FULL  = -P_FULL;
  localparam logic signed [OUT_W-1:0] P_THIRD = OUT_W'(AMP / 3);
  localparam logic signed [OUT_W-1:0] N_THIRD = -P_THIRD;

  logic [LFSR_W-1:0]       r_lfsr;
  logic signed [OUT_W-1:0] r_i;
  logic signed [OUT_W-1:0] r_q;
  logic                    r_valid;
  logic                    r_last;
  logic [15:0]             r_cnt;
  logic [15:0]             r_flen;

  mode_e                   w_mode;
  logic [2:0]              w_nsteps;
  logic [LFSR_W-1:0]       w_next;
  logic [3:0]              w_bits;
  logic                    w_produce;
  logic signed [OUT_W-1:0] w_i;
  logic signed [OUT_W-1:0] w_q;
  logic [15:0]             w_flen;
  logic [15:0]             w_cnt_inc;
  logic [15:0]             w_cnt_next;
  logic                    w_last;

  function automatic logic signed [OUT_W-1:0] antipodal(input logic b);
    return b ? N_FULL : P_FULL;
  endfunction

  function automatic logic signed [OUT_W-1:0] level_value(input level_e l);
    case (l)
      LVL_NEG_FULL:  return N_FULL;
      LVL_NEG_THIRD: return N_THIRD;
      LVL_POS_THIRD: return P_THIRD;
      default:       return P_FULL;
    endcase
  endfunction

  assign w_mode   = mode_e'(mode);
  assign w_nsteps = bits_per_symbol(w_mode);

  prbs_stepper #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS)
  ) u_stepper (
    .i_state  (r_lfsr),
    .i_nsteps (w_nsteps),
    .o_next   (w_next),
    .o_bits   (w_bits)
  );

  assign w_produce = enable && (w_mode != MODE_RSVD) && !lfsr_load && (!r_valid || ready_in);

  always_comb begin
    w_i = '0;
    w_q = '0;
    case (w_mode)
      MODE_BPSK: begin
        w_i = antipodal(w_bits[0]);
      end
      MODE_QPSK: begin
        w_i = antipodal(w_bits[0]);
        w_q = antipodal(w_bits[1]);
      end
      MODE_QAM16: begin
        w_i = level_value(gray_level({w_bits[0], w_bits[1]}));
        w_q = level_value(gray_level({w_bits[2], w_bits[3]}));
      end
      default: ;
    endcase
  end

  // frame_len is only picked up at a frame boundary so a mid-frame change
  // cannot truncate or stretch the frame in flight
  always_comb begin
    w_flen     = (r_cnt == 16'd0) ? frame_len : r_flen;
    w_cnt_inc  = r_cnt + 16'd1;
    w_last     = (w_flen != 16'd0) && (w_cnt_inc == w_flen);
    w_cnt_next = ((w_flen == 16'd0) || w_last) ? 16'd0 : w_cnt_inc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr  <= '1;
      r_i     <= '0;
      r_q     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_flen  <= '0;
    end else if (lfsr_load) begin
      r_lfsr  <= (lfsr_seed == '0) ? LFSR_W'(1) : lfsr_seed;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_produce) begin
      r_lfsr  <= w_next;
      r_i     <= w_i;
      r_q     <= w_q;
      r_valid <= 1'b1;
      r_last  <= w_last;
      r_cnt   <= w_cnt_next;
      if (r_cnt == 16'd0) r_flen <= frame_len;
    end else if (r_valid && ready_in) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign I_out     = r_i;
  assign Q_out     = r_q;
  assign valid_out = r_valid;
  assign last_out  = r_last;

endmodule
